serial_adder: RTL and testbench

- Bit-serial ripple adder built around a single one-bit full-adder cell.
- Loads two WIDTH-bit operands plus carry-in, then feeds one bit pair per clock, LSB first, through the full adder. A carry flop closes the loop.
- It is the sequential driver stage directly upstream of the one-bit full adder: it supplies a/b/c and consumes out/carry each cycle.
- Parallel result and a done pulse go to downstream logic.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/serial_adder_fa_bit.sv | 16 +
 rtl/serial_adder.sv | 104 ++++++++++
 tb/tb_serial_adder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM encodings, default width and
// the majority helper used by the one-bit full-adder cell.
package serial_adder_pkg;

  localparam int unsigned DefaultWidth = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_adder_fa_bit.sv
// Purely combinational one-bit full adder: out is the sum bit, carry the
// majority of the three inputs.
module fa_bit
  import serial_adder_pkg::*;
(
  output logic out,
  output logic carry,
  input  logic a,
  input  logic b,
  input  logic c
);

  assign out   = a ^ b ^ c;
  assign carry = maj3(a, b, c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: loads two operands plus carry-in, then adds one bit
// pair per clock LSB first through a single full-adder cell.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             fa_s, fa_co;

  fa_bit u_fa_bit (
    .out   (fa_s),
    .carry (fa_co),
    .a     (a_sr_q[0]),
    .b     (b_sr_q[0]),
    .c     (carry_q)
  );

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    c_out_d  = c_out_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE accepts start just like IDLE so back-to-back runs have no gap.
        state_d = ST_IDLE;
        if (start) begin
          a_sr_d  = a_in;
          b_sr_d  = b_in;
          carry_d = c_in;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
        carry_d  = fa_co;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          sum_d   = {fa_s, sum_sr_q[WIDTH-1:1]};
          c_out_d = fa_co;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      c_out_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      c_out_q  <= c_out_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and swept checks of serial_adder at WIDTH=8.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         c_in = 1'b0;
  logic         busy, done, c_out;
  logic [W-1:0] sum;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int acc_cnt = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge where start is driven; returns negedges until done.
  task automatic wait_done(input bit drop_start, output int cyc, output int nbusy);
    cyc = 0;
    nbusy = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && drop_start) start = 1'b0;
      if (busy) nbusy++;
    end while (!done && cyc < 40);
  endtask

  task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input string tag);
    int cyc, nb;
    logic [W:0] exp;
    exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    @(negedge clk);
    start = 1'b1; a_in = a; b_in = b; c_in = c;
    wait_done(1'b1, cyc, nb);
    acc_cnt++;
    check_eq({tag, " latency"}, cyc, W + 1);
    check_eq({tag, " busy cycles"}, nb, W);
    check_eq({tag, " result"}, {23'd0, c_out, sum}, {23'd0, exp});
    @(negedge clk);
    check_eq({tag, " done pulse width"}, done, 1'b0);
  endtask

  initial begin
    int cyc, nb, d0;

    #12;
    check_eq("reset busy", busy, 1'b0);
    check_eq("reset done", done, 1'b0);
    check_eq("reset sum", sum, 0);
    check_eq("reset c_out", c_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_add(8'h5A, 8'h3C, 1'b0, "5a+3c");
    check_eq("5a+3c sum", sum, 8'h96);
    run_add(8'hFF, 8'h01, 1'b0, "ff+01");
    check_eq("ff+01 c_out", c_out, 1'b1);
    run_add(8'h00, 8'h00, 1'b1, "0+0+1");
    check_eq("0+0+1 sum", sum, 8'h01);

    // Start during RUN must be ignored, operand changes must not leak in.
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; a_in = 8'h10; b_in = 8'h20; c_in = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (cyc == 3) begin start = 1'b1; a_in = 8'hFF; b_in = 8'hFF; c_in = 1'b1; end
      if (cyc == 4) start = 1'b0;
    end while (!done && cyc < 40);
    acc_cnt++;
    check_eq("midrun latency", cyc, W + 1);
    check_eq("midrun result", {c_out, sum}, 9'h030);
    @(negedge clk);
    #1;
    check_eq("midrun single done", done_cnt - d0, 1);
    check_eq("midrun no requeue", busy, 1'b0);

    // Back-to-back: start held, new operands presented in the DONE cycle.
    @(negedge clk);
    start = 1'b1; a_in = 8'h80; b_in = 8'h80; c_in = 1'b0;
    wait_done(1'b0, cyc, nb);
    check_eq("b2b first latency", cyc, W + 1);
    check_eq("b2b first result", {c_out, sum}, 9'h100);
    a_in = 8'h01; b_in = 8'h02;
    wait_done(1'b1, cyc, nb);
    acc_cnt += 2;
    check_eq("b2b second latency", cyc, W + 1);
    check_eq("b2b second busy", nb, W);
    check_eq("b2b second result", {c_out, sum}, 9'h003);

    run_add(8'hFF, 8'hFF, 1'b0, "ff+ff");

    // Asynchronous reset mid-run at bit 4.
    @(negedge clk);
    start = 1'b1; a_in = 8'hAA; b_in = 8'h55; c_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("pre-reset busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async reset busy", busy, 1'b0);
    check_eq("async reset done", done, 1'b0);
    check_eq("async reset sum", sum, 0);
    check_eq("async reset c_out", c_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    nb = 0;
    repeat (15) begin
      @(negedge clk);
      if (busy) nb++;
    end
    #1;
    check_eq("post-reset no done", done_cnt - d0, 0);
    check_eq("post-reset idle", nb, 0);

    for (int i = 0; i < 200; i++) begin
      run_add(W'($urandom), W'($urandom), 1'($urandom_range(1, 0)), "sweep");
    end

    @(negedge clk);
    #1;
    check_eq("done count", done_cnt, acc_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
